// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the elastic inter-stage pipeline buffers.
//   - pbuf_state_t : occupancy state of one buffer (EMPTY / ONE / FULL)
//   - pbuf_occ()   : state -> live-entry count (0..2)
//   - d2e_t        : example decode->execute payload; stage instances pass
//                    $bits(d2e_t) as WIDTH and D2E_BUBBLE as BUBBLE.
package pipe_stage_buf_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pbuf_state_t;

    typedef enum logic [3:0] {
        ALU_ADDU = 4'd0,
        ALU_SUBU = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        reg_write;
        alu_op_t     alu_op;
        msize_t      msize;
    } d2e_t;

    // A bubble must be architecturally harmless: no register write, a
    // side-effect-free ALU op and the default memory size.
    localparam d2e_t D2E_BUBBLE = '{
        pc:        32'd0,
        rd:        5'd0,
        reg_write: 1'b0,
        alu_op:    ALU_ADDU,
        msize:     MSIZE4
    };

    function automatic logic [OCC_W-1:0] pbuf_occ(input pbuf_state_t st);
        case (st)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline register between two pipeline stages.
// Ports:
//   clk        in   1      rising-edge clock
//   resetn     in   1      asynchronous active-low reset
//   flush      in   1      synchronous kill of every entry (wins over stall)
//   stall      in   1      hold everything; blocks input and output transfers
//   in_valid   in   1      upstream payload valid
//   in_ready   out  1      buffer accepts this cycle
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      out_data holds a live entry
//   out_ready  in   1      downstream accepts
//   out_data   out  WIDTH  head entry, BUBBLE when empty
//   occupancy  out  2      live entries (0..2, or 0..1 when SKID=0)
// SKID=1 gives a two-entry buffer whose in_ready depends only on flops (and
// stall, itself a flop upstream). SKID=0 is a single entry whose in_ready
// looks through to out_ready.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int               WIDTH  = 64,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter bit               SKID   = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             stall,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    pbuf_state_t      r_state;
    pbuf_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             r_live;
    logic             w_in_fire;
    logic             w_out_fire;

    // r_live keeps in_ready low during reset and raises it on the first edge
    // after release, without putting resetn on a combinational path.
    assign out_valid = (r_state != EMPTY);
    assign in_ready  = r_live & ~stall &
                       (SKID ? (r_state != FULL) : (out_ready | ~out_valid));
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready & ~stall;

    // Entries are cleared to BUBBLE whenever they die, so main is always the
    // correct output value.
    assign out_data  = r_main;
    assign occupancy = pbuf_occ(r_state);

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = EMPTY;
            w_main_nxt  = BUBBLE;
            w_skid_nxt  = BUBBLE;
        end else begin
            // stall forces both fires low, so no case needs to test it.
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = in_data;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = in_data;
                    end else if (w_in_fire && SKID) begin
                        // Newer payload parks behind main, preserving order.
                        w_state_nxt = FULL;
                        w_skid_nxt  = in_data;
                    end else if (w_out_fire) begin
                        w_state_nxt = EMPTY;
                        w_main_nxt  = BUBBLE;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = BUBBLE;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                    w_main_nxt  = BUBBLE;
                    w_skid_nxt  = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= EMPTY;
            r_main  <= BUBBLE;
            r_skid  <= BUBBLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
            r_live  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

    localparam int         W   = 8;
    localparam logic [7:0] BUB = 8'hE5;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         flush = 1'b0;
    logic         stall = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;

    logic         ir1, ov1, ir0, ov0;
    logic [W-1:0] od1, od0;
    logic [1:0]   occ1, occ0;

    int total = 0;
    int bad   = 0;

    pipe_stage_buf #(.WIDTH(W), .BUBBLE(BUB), .SKID(1'b1)) u_dut (
        .clk(clk), .resetn(resetn), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(occ1)
    );

    pipe_stage_buf #(.WIDTH(W), .BUBBLE(BUB), .SKID(1'b0)) u_dut0 (
        .clk(clk), .resetn(resetn), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .occupancy(occ0)
    );

    always #5 clk = ~clk;

    // Reference model: each buffer is a FIFO of bounded capacity.
    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];
    bit           alive = 1'b0;

    logic         e_ir1, e_ov1, e_ir0, e_ov0;
    logic [W-1:0] e_od1, e_od0;
    logic [1:0]   e_occ1, e_occ0;

    task automatic calc();
        e_ov1  = (q1.size() > 0);
        e_od1  = e_ov1 ? q1[0] : BUB;
        e_occ1 = 2'(q1.size());
        e_ir1  = alive && resetn && !stall && (q1.size() < 2);
        e_ov0  = (q0.size() > 0);
        e_od0  = e_ov0 ? q0[0] : BUB;
        e_occ0 = 2'(q0.size());
        e_ir0  = alive && resetn && !stall && (out_ready || q0.size() == 0);
    endtask

    task automatic settle();
        #1;
        calc();
    endtask

    // One clock: model transfers decided from the pre-edge view, then move to
    // just after the next falling edge.
    task automatic advance();
        bit if1, of1, if0, of0;
        logic [W-1:0] d;
        calc();
        if1 = in_valid && e_ir1;
        of1 = e_ov1 && out_ready && !stall;
        if0 = in_valid && e_ir0;
        of0 = e_ov0 && out_ready && !stall;
        d = in_data;
        @(posedge clk);
        if (resetn) begin
            alive = 1'b1;
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (of1) void'(q1.pop_front());
                if (if1) q1.push_back(d);
                if (of0) void'(q0.pop_front());
                if (if0) q0.push_back(d);
            end
        end
        @(negedge clk);
        settle();
    endtask

    task automatic set_in(input bit iv, input logic [W-1:0] id, input bit ordy,
                          input bit st, input bit fl);
        in_valid = iv; in_data = id; out_ready = ordy; stall = st; flush = fl;
        settle();
    endtask

    task automatic test_reset();
        // Power-on reset then release.
        @(negedge clk);
        settle();
        total++;
        if ({ir1, ov1, od1, occ1} !== {1'b0, 1'b0, BUB, 2'd0}) begin
            bad++;
            $display("FAIL reset_hold got=%h exp=%h", {ir1, ov1, od1, occ1}, {1'b0, 1'b0, BUB, 2'd0});
        end
        resetn = 1'b1;
        advance();
        total++;
        if (ir1 !== 1'b1 || ir0 !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b%b exp=11", ir1, ir0);
        end
        // Fill to FULL, then reset asynchronously mid-operation.
        set_in(1, 8'h3C, 0, 0, 0); advance();
        set_in(1, 8'h4D, 0, 0, 0); advance();
        total++;
        if (occ1 !== 2'd2) begin
            bad++;
            $display("FAIL reset_fill_occ got=%0d exp=2", occ1);
        end
        set_in(0, 8'h00, 0, 0, 0);
        resetn = 1'b0;
        q1.delete(); q0.delete(); alive = 1'b0;
        settle();
        total++;
        if ({ir1, ov1, od1, occ1, ov0, od0} !== {1'b0, 1'b0, BUB, 2'd0, 1'b0, BUB}) begin
            bad++;
            $display("FAIL reset_async got=%h exp=%h", {ir1, ov1, od1, occ1, ov0, od0},
                     {1'b0, 1'b0, BUB, 2'd0, 1'b0, BUB});
        end
        advance();
        resetn = 1'b1;
        settle();
        total++;
        if (ir1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_pre_edge_ready got=%b exp=0", ir1);
        end
        advance();
        total++;
        if (ir1 !== 1'b1) begin
            bad++;
            $display("FAIL reset_post_edge_ready got=%b exp=1", ir1);
        end
    endtask

    task automatic test_stream();
        logic [W-1:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            set_in(1, vals[i], 1, 0, 0);
            advance();
            total++;
            if ({ov1, od1, occ1} !== {1'b1, vals[i], 2'd1} ||
                {ov1, od1, occ1} !== {e_ov1, e_od1, e_occ1}) begin
                bad++;
                $display("FAIL stream_c%0d got=%h exp=%h", i + 1, {ov1, od1, occ1}, {1'b1, vals[i], 2'd1});
            end
        end
        set_in(0, 8'h00, 1, 0, 0);
        advance();
        total++;
        if ({ov1, od1, occ1} !== {1'b0, BUB, 2'd0}) begin
            bad++;
            $display("FAIL stream_drain got=%h exp=%h", {ov1, od1, occ1}, {1'b0, BUB, 2'd0});
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] got[$];
        bit c_sent;
        set_in(1, 8'h0A, 0, 0, 0); advance();
        set_in(1, 8'h0B, 0, 0, 0); advance();
        set_in(1, 8'h0C, 0, 0, 0);
        total++;
        if ({occ1, ir1} !== {2'd2, 1'b0}) begin
            bad++;
            $display("FAIL bp_full got=%h exp=%h", {occ1, ir1}, {2'd2, 1'b0});
        end
        advance();
        c_sent = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle();
            if (!c_sent && ir1) c_sent = 1'b1;
            if (ov1) got.push_back(od1);
            total++;
            if ({ir1, ov1, od1, occ1} !== {e_ir1, e_ov1, e_od1, e_occ1}) begin
                bad++;
                $display("FAIL bp_cycle%0d got=%h exp=%h", i, {ir1, ov1, od1, occ1}, {e_ir1, e_ov1, e_od1, e_occ1});
            end
            advance();
            if (c_sent) in_valid = 1'b0;
        end
        total++;
        if (got.size() != 3 || got[0] !== 8'h0A || got[1] !== 8'h0B || got[2] !== 8'h0C) begin
            bad++;
            $display("FAIL bp_order got_n=%0d got=%p exp=0a,0b,0c", got.size(), got);
        end
    endtask

    task automatic test_flush();
        set_in(1, 8'h0A, 0, 0, 0); advance();
        set_in(1, 8'h0B, 0, 0, 0); advance();
        set_in(1, 8'h0D, 0, 0, 1); advance();
        total++;
        if ({ov1, od1, occ1, ov0, od0} !== {1'b0, BUB, 2'd0, 1'b0, BUB}) begin
            bad++;
            $display("FAIL flush_empty got=%h exp=%h", {ov1, od1, occ1, ov0, od0}, {1'b0, BUB, 2'd0, 1'b0, BUB});
        end
        set_in(0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ov1 !== 1'b0 || od1 === 8'h0D) begin
                bad++;
                $display("FAIL flush_no_d got=%b/%h exp=0/%h", ov1, od1, BUB);
            end
            advance();
        end
    endtask

    task automatic test_stall();
        set_in(1, 8'h05, 0, 0, 0); advance();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 8'h77, 1, 1, 0);
            total++;
            if ({od1, ir1, occ1} !== {8'h05, 1'b0, 2'd1}) begin
                bad++;
                $display("FAIL stall_c%0d got=%h exp=%h", i, {od1, ir1, occ1}, {8'h05, 1'b0, 2'd1});
            end
            advance();
        end
        set_in(0, 8'h00, 1, 0, 0);
        total++;
        if ({ov1, od1, occ1} !== {1'b1, 8'h05, 2'd1}) begin
            bad++;
            $display("FAIL stall_release got=%h exp=%h", {ov1, od1, occ1}, {1'b1, 8'h05, 2'd1});
        end
        advance();
        advance();
    endtask

    task automatic test_skid0();
        set_in(1, 8'h21, 0, 0, 0); advance();
        set_in(0, 8'h00, 0, 0, 0);
        total++;
        if ({ir0, ov0, occ0} !== {1'b0, 1'b1, 2'd1}) begin
            bad++;
            $display("FAIL skid0_blocked got=%h exp=%h", {ir0, ov0, occ0}, {1'b0, 1'b1, 2'd1});
        end
        set_in(1, 8'h09, 1, 0, 0);
        total++;
        if (ir0 !== 1'b1) begin
            bad++;
            $display("FAIL skid0_lookthrough got=%b exp=1", ir0);
        end
        advance();
        total++;
        if ({ov0, od0, occ0} !== {1'b1, 8'h09, 2'd1}) begin
            bad++;
            $display("FAIL skid0_next got=%h exp=%h", {ov0, od0, occ0}, {1'b1, 8'h09, 2'd1});
        end
        set_in(0, 8'h00, 1, 0, 1); advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(3) != 0), 8'($urandom), $urandom_range(1),
                   ($urandom_range(7) == 0), ($urandom_range(15) == 0));
            total++;
            if ({ir1, ov1, od1, occ1, ir0, ov0, od0, occ0} !==
                {e_ir1, e_ov1, e_od1, e_occ1, e_ir0, e_ov0, e_od0, e_occ0}) begin
                bad++;
                $display("FAIL random_c%0d got=%h exp=%h", i,
                         {ir1, ov1, od1, occ1, ir0, ov0, od0, occ0},
                         {e_ir1, e_ov1, e_od1, e_occ1, e_ir0, e_ov0, e_od0, e_occ0});
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_stall();
        test_skid0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
